// File: rtl/barrel_thread_sched.sv
// Round-robin fetch thread scheduler for the barrel core: one PC per thread, active mask, fetch-slot outputs.
// Latency: one cycle from selection to pc_f_o/tid_f_o/valid_f_o; table writes are visible at the thread's next issue.
// Backpressure: stall_i freezes the fetch slot, rr pointer and +4 increments; redirect/start/halt still land.
//
// Optional feature macro: SCHED_PERF_CNT_EN (adds issue_cnt_o / bubble_cnt_o, 32-bit wrapping counters).
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   stall_i                            global stall from the hazard unit
//   redirect_i/_tid_i/_pc_i            taken branch/jump: new PC for one thread
//   start_i/_tid_i/_pc_i               activate a thread at a given PC
//   halt_i/_tid_i                      deactivate a thread
//   pc_f_o, tid_f_o, valid_f_o         fetch slot presented to imem and the F/D register
//   en_fd_o, clr_fd_o                  F/D register hold (1 = hold) and clear (bubble)
//   active_o, idle_o                   active-thread mask, no-thread-active flag
module barrel_thread_sched #(
    parameter int NUM_THREADS   = 8,
    parameter int BITS_THREADS  = 3,
    parameter int ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [BITS_THREADS-1:0]  redirect_tid_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
    input  logic                     start_i,
    input  logic [BITS_THREADS-1:0]  start_tid_i,
    input  logic [ADDRESS_WIDTH-1:0] start_pc_i,
    input  logic                     halt_i,
    input  logic [BITS_THREADS-1:0]  halt_tid_i,
    output logic [ADDRESS_WIDTH-1:0] pc_f_o,
    output logic [BITS_THREADS-1:0]  tid_f_o,
    output logic                     valid_f_o,
    output logic                     en_fd_o,
    output logic                     clr_fd_o,
    output logic [NUM_THREADS-1:0]   active_o,
    output logic                     idle_o
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]              issue_cnt_o,
    output logic [31:0]              bubble_cnt_o
`endif
);

    logic [ADDRESS_WIDTH-1:0] r_pc_table [NUM_THREADS];
    logic [NUM_THREADS-1:0]   r_active;
    logic [BITS_THREADS-1:0]  r_rr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_pc_f;
    logic [BITS_THREADS-1:0]  r_tid_f;
    logic                     r_valid_f;

    logic                     w_sel_vld;
    logic [BITS_THREADS-1:0]  w_sel;
    logic                     w_issue;
    logic [NUM_THREADS-1:0]   w_active_nxt;
    logic                     w_squash;

    // Circular search starting just after rr_ptr. Walking the offsets from
    // farthest to nearest lets the nearest active thread overwrite the rest.
    // Offset NUM_THREADS wraps to rr_ptr itself, covering the single-thread case.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = r_rr_ptr;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            if (r_active[r_rr_ptr + BITS_THREADS'(k)]) begin
                w_sel_vld = 1'b1;
                w_sel     = r_rr_ptr + BITS_THREADS'(k);
            end
        end
    end

    assign w_issue = w_sel_vld && !stall_i;

    // Halt is applied after start so a same-cycle start+halt leaves the bit clear.
    always_comb begin
        w_active_nxt = r_active;
        if (start_i) begin
            w_active_nxt[start_tid_i] = 1'b1;
        end
        if (halt_i) begin
            w_active_nxt[halt_tid_i] = 1'b0;
        end
    end

    // PC table: start beats redirect beats the issue increment on the same entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (!rst_n) begin
                r_pc_table[i] <= (i == 0) ? RESET_PC : '0;
            end else if (start_i && start_tid_i == BITS_THREADS'(i)) begin
                r_pc_table[i] <= start_pc_i;
            end else if (redirect_i && redirect_tid_i == BITS_THREADS'(i)) begin
                r_pc_table[i] <= redirect_pc_i;
            end else if (w_issue && w_sel == BITS_THREADS'(i)) begin
                r_pc_table[i] <= r_pc_table[i] + ADDRESS_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active  <= NUM_THREADS'(1);
            r_rr_ptr  <= BITS_THREADS'(NUM_THREADS - 1);
            r_pc_f    <= '0;
            r_tid_f   <= '0;
            r_valid_f <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            if (!stall_i) begin
                if (w_sel_vld) begin
                    r_pc_f    <= r_pc_table[w_sel];
                    r_tid_f   <= w_sel;
                    r_valid_f <= 1'b1;
                    r_rr_ptr  <= w_sel;
                end else begin
                    r_valid_f <= 1'b0;
                end
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_issue_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (!stall_i) begin
            if (w_sel_vld) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end else begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign issue_cnt_o  = r_issue_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

    // The presented slot is wrong-path if its own thread is redirected or
    // halted this cycle; the F/D register must then take a bubble instead.
    assign w_squash = r_valid_f &&
                      ((redirect_i && redirect_tid_i == r_tid_f) ||
                       (halt_i && halt_tid_i == r_tid_f));

    assign pc_f_o    = r_pc_f;
    assign tid_f_o   = r_tid_f;
    assign valid_f_o = r_valid_f;
    assign en_fd_o   = stall_i;
    assign clr_fd_o  = !stall_i && (!r_valid_f || w_squash);
    assign active_o  = r_active;
    assign idle_o    = (r_active == '0);

endmodule

// File: tb/tb_barrel_thread_sched.sv
// Scoreboard bench for barrel_thread_sched: directed scenarios followed by random traffic.
// Expected fetch slots are queued by the driver from a thread-level model and popped by a monitor.
// Combinational controls (en/clr/active/idle) are checked by the driver each cycle.
module tb_barrel_thread_sched;
    localparam int NT = 8;
    localparam int BT = 3;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i;
    logic          redirect_i;
    logic [BT-1:0] redirect_tid_i;
    logic [AW-1:0] redirect_pc_i;
    logic          start_i;
    logic [BT-1:0] start_tid_i;
    logic [AW-1:0] start_pc_i;
    logic          halt_i;
    logic [BT-1:0] halt_tid_i;
    logic [AW-1:0] pc_f_o;
    logic [BT-1:0] tid_f_o;
    logic          valid_f_o;
    logic          en_fd_o;
    logic          clr_fd_o;
    logic [NT-1:0] active_o;
    logic          idle_o;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   issue_cnt_o;
    logic [31:0]   bubble_cnt_o;
`endif

    always #5 clk = ~clk;

    barrel_thread_sched #(
        .NUM_THREADS(NT), .BITS_THREADS(BT), .ADDRESS_WIDTH(AW), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_tid_i(redirect_tid_i), .redirect_pc_i(redirect_pc_i),
        .start_i(start_i), .start_tid_i(start_tid_i), .start_pc_i(start_pc_i),
        .halt_i(halt_i), .halt_tid_i(halt_tid_i),
        .pc_f_o(pc_f_o), .tid_f_o(tid_f_o), .valid_f_o(valid_f_o),
        .en_fd_o(en_fd_o), .clr_fd_o(clr_fd_o), .active_o(active_o), .idle_o(idle_o)
`ifdef SCHED_PERF_CNT_EN
        , .issue_cnt_o(issue_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] pc;
        logic [BT-1:0] tid;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: per-thread PCs, active set, last thread issued, fetch slot.
    logic [AW-1:0] m_pc [NT];
    logic [NT-1:0] m_act;
    int            m_last;
    logic          m_valid;
    logic [AW-1:0] m_pc_f;
    logic [BT-1:0] m_tid_f;
    int            m_nonstall;
    int            m_issues;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next thread in round-robin order after the last one issued; -1 if none active.
    function automatic int pick();
        for (int k = 1; k <= NT; k++) begin
            int t;
            t = (m_last + k) % NT;
            if (m_act[t]) return t;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) m_pc[i] = '0;
        m_act      = 8'h01;
        m_last     = NT - 1;
        m_valid    = 1'b0;
        m_pc_f     = '0;
        m_tid_f    = '0;
        m_nonstall = 0;
        m_issues   = 0;
    endfunction

    // Monitor: every non-stalled, non-reset edge produces one fetch-slot update.
    logic mon_st, mon_rs;
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            mon_st = stall_i;
            mon_rs = rst_n;
            #1;
            if (mon_rs && !mon_st) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got DUT update with empty queue at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("valid_f", 64'(valid_f_o), 64'(mon_e.v));
                    check("pc_f", 64'(pc_f_o), 64'(mon_e.pc));
                    check("tid_f", 64'(tid_f_o), 64'(mon_e.tid));
                end
            end
        end
    end

    task automatic do_reset(input logic junk);
        @(negedge clk);
        rst_n          = 1'b0;
        stall_i        = junk;
        redirect_i     = junk;
        redirect_tid_i = '0;
        redirect_pc_i  = 32'h1234_5678;
        start_i        = junk;
        start_tid_i    = 3'd1;
        start_pc_i     = 32'h0000_0abc;
        halt_i         = junk;
        halt_tid_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_pc_f", 64'(pc_f_o), 64'(0));
        check("rst_tid_f", 64'(tid_f_o), 64'(0));
        check("rst_valid_f", 64'(valid_f_o), 64'(0));
        check("rst_active", 64'(active_o), 64'(1));
        check("rst_idle", 64'(idle_o), 64'(0));
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [BT-1:0] rt, input logic [AW-1:0] rp,
                         input logic sa, input logic [BT-1:0] stid, input logic [AW-1:0] spc,
                         input logic hl, input logic [BT-1:0] ht);
        int   s;
        logic exp_clr;
        logic squash;
        @(negedge clk);
        rst_n          = 1'b1;
        stall_i        = st;
        redirect_i     = rd;
        redirect_tid_i = rt;
        redirect_pc_i  = rp;
        start_i        = sa;
        start_tid_i    = stid;
        start_pc_i     = spc;
        halt_i         = hl;
        halt_tid_i     = ht;
        #1;
        squash  = m_valid && ((rd && rt == m_tid_f) || (hl && ht == m_tid_f));
        exp_clr = !st && (!m_valid || squash);
        check("en_fd", 64'(en_fd_o), 64'(st));
        check("clr_fd", 64'(clr_fd_o), 64'(exp_clr));
        check("active", 64'(active_o), 64'(m_act));
        check("idle", 64'(idle_o), 64'(m_act == 0));
        // Advance the model across the coming edge using pre-edge state.
        if (!st) begin
            m_nonstall++;
            s = pick();
            if (s >= 0) begin
                m_issues++;
                m_valid = 1'b1;
                m_pc_f  = m_pc[s];
                m_tid_f = BT'(s);
                m_last  = s;
                m_pc[s] = m_pc[s] + 32'd4;
            end else begin
                m_valid = 1'b0;
            end
            sb_q.push_back('{v: m_valid, pc: m_pc_f, tid: m_tid_f});
        end
        if (rd) m_pc[rt] = rp;
        if (sa) m_pc[stid] = spc;
        if (sa) m_act[stid] = 1'b1;
        if (hl) m_act[ht] = 1'b0;
    endtask

    task automatic nop();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_tid_i = '0; redirect_pc_i = '0;
        start_i = 1'b0; start_tid_i = '0; start_pc_i = '0; halt_i = 1'b0; halt_tid_i = '0;
        model_reset();

        do_reset(1'b0);
        // Thread 0 alone: 0,4,8,...
        repeat (5) nop();
        // Add threads 2 and 5.
        cycle(0, 0, 0, 0, 1, 3'd2, 32'h100, 0, 0);
        cycle(0, 0, 0, 0, 1, 3'd5, 32'h200, 0, 0);
        repeat (6) nop();
        // Three-cycle stall mid-sequence.
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) nop();
        // Redirect thread 2 while it is presented.
        for (int i = 0; i < 16; i++) begin
            if (m_valid && m_tid_f == 3'd2) begin
                cycle(0, 1, 3'd2, 32'h400, 0, 0, 0, 0, 0);
                break;
            end
            nop();
        end
        repeat (6) nop();
        // Halt every thread, then restart thread 3.
        for (int i = 0; i < NT; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, BT'(i));
        repeat (3) nop();
        cycle(0, 0, 0, 0, 1, 3'd3, 32'h80, 0, 0);
        repeat (3) nop();
        // Same-cycle start+halt, and PC wraparound.
        cycle(0, 0, 0, 0, 1, 3'd4, 32'h40, 1, 3'd4);
        cycle(0, 1, 3'd3, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        repeat (4) nop();
        // Start during stall and redirect+start collision on one thread.
        cycle(1, 1, 3'd6, 32'h600, 1, 3'd6, 32'h660, 0, 0);
        repeat (4) nop();
        // Reset arriving mid-stall and mid-redirect.
        cycle(1, 1, 3'd3, 32'h900, 0, 0, 0, 0, 0);
        do_reset(1'b1);
        repeat (3) nop();
        // Random traffic.
        for (int n = 0; n < 2500; n++) begin
            cycle(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), BT'($urandom_range(0, NT - 1)), $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 4) == 0), BT'($urandom_range(0, NT - 1)), $urandom,
                  ($urandom_range(0, 7) == 0), BT'($urandom_range(0, NT - 1)));
        end
        // Freeze the DUT and let the monitor drain.
        @(negedge clk);
        stall_i = 1'b1; redirect_i = 1'b0; start_i = 1'b0; halt_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", 64'(sb_q.size()), 64'(0));
`ifdef SCHED_PERF_CNT_EN
        check("perf_total", 64'(issue_cnt_o + bubble_cnt_o), 64'(m_nonstall));
        check("perf_issue", 64'(issue_cnt_o), 64'(m_issues));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
